// File: rtl/ssd_word_decoder.sv
// ----------------------------------------------------------------------------
// ssd_word_decoder
//
// Turns a stream of active-low seven-segment digit patterns back into 16-bit
// binary words. One pattern is accepted per SegValid strobe, most significant
// digit first. After four digits the assembled word is registered on Word and
// WordValid pulses for one cycle. An unmapped pattern moves the decoder into
// an error state (Err high, input ignored) until Sync or Clr.
//
// Optional feature macro: SSD_DECODE_BLANK_EN
//   defined   -> the blank pattern 1111111 is a valid digit that decodes to 0
//   undefined -> 1111111 is invalid like any other unmapped pattern
//
// Ports:
//   Clk        in   rising-edge clock
//   Clr        in   asynchronous active-high reset
//   Seg[0:6]   in   segment pattern, active-low, Seg[0]=a ... Seg[6]=g
//   SegValid   in   Seg is sampled on this rising edge
//   Sync       in   synchronous frame restart (clears Err and partial word)
//   Word       out  last completed word, held until the next completion
//   WordValid  out  one-cycle pulse in the cycle after the 4th digit edge
//   Err        out  sticky invalid-pattern flag for the current frame
//   DigitCnt   out  digits accepted in the current frame (0..3)
//   FsmState   out  debug view of the FSM state (0 = COLLECT, 1 = ERR)
//
// Handshake: SegValid is a plain strobe with no ready/backpressure; every
// cycle with SegValid high presents exactly one digit, and the decoder either
// consumes it (COLLECT, or any state with Sync) or drops it (ERR).
// ----------------------------------------------------------------------------
module ssd_word_decoder (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [0:6]  Seg,
    input  logic        SegValid,
    input  logic        Sync,
    output logic [15:0] Word,
    output logic        WordValid,
    output logic        Err,
    output logic [1:0]  DigitCnt,
    output logic [0:0]  FsmState
);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_ERR     = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [11:0] acc_q,   acc_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic [15:0] word_q,  word_d;
    logic        wv_q,    wv_d;

    logic [3:0]  nib;
    logic        nib_ok;

    // Pattern decode. Seg is declared [0:6], so a 7'b literal maps its
    // leftmost bit onto segment a, matching how the patterns are written.
    always_comb begin
        nib    = 4'h0;
        nib_ok = 1'b1;
        case (Seg)
            7'b0000001: nib = 4'h0;
            7'b1001111: nib = 4'h1;
            7'b0010010: nib = 4'h2;
            7'b0000110: nib = 4'h3;
            7'b1001100: nib = 4'h4;
            7'b0100100: nib = 4'h5;
            7'b0100000: nib = 4'h6;
            7'b0001111: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0001100: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b1100000: nib = 4'hB;
            7'b0110001: nib = 4'hC;
            7'b1000010: nib = 4'hD;
            7'b0110000: nib = 4'hE;
            7'b0111000: nib = 4'hF;
`ifdef SSD_DECODE_BLANK_EN
            7'b1111111: nib = 4'h0;
`endif
            default:    nib_ok = 1'b0;
        endcase
    end

    // Sync restarts the frame first; a digit arriving in the same cycle is
    // then treated as the first digit of the fresh frame, which is why the
    // accumulator and counter are taken from these "base" values.
    logic [11:0] acc_base;
    logic [1:0]  cnt_base;
    logic        take_digit;

    always_comb begin
        acc_base   = Sync ? 12'h000 : acc_q;
        cnt_base   = Sync ? 2'd0    : cnt_q;
        take_digit = SegValid && (Sync || (state_q == ST_COLLECT));

        state_d = Sync ? ST_COLLECT : state_q;
        acc_d   = acc_base;
        cnt_d   = cnt_base;
        word_d  = word_q;
        wv_d    = 1'b0;

        if (take_digit) begin
            if (nib_ok) begin
                if (cnt_base == 2'd3) begin
                    word_d = {acc_base, nib};
                    wv_d   = 1'b1;
                    acc_d  = 12'h000;
                    cnt_d  = 2'd0;
                end else begin
                    acc_d = {acc_base[7:0], nib};
                    cnt_d = cnt_base + 2'd1;
                end
            end else begin
                // Partial word and counter stay as they are, frozen for debug.
                state_d = ST_ERR;
            end
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= ST_COLLECT;
            acc_q   <= 12'h000;
            cnt_q   <= 2'd0;
            word_q  <= 16'h0000;
            wv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wv_q    <= wv_d;
        end
    end

    assign Word      = word_q;
    assign WordValid = wv_q;
    assign Err       = (state_q == ST_ERR);
    assign DigitCnt  = cnt_q;
    assign FsmState  = state_q;

endmodule
